// File: rtl/elbeth_mem_arbiter_pkg.sv
// Shared encodings for the elbeth I/D memory arbiter: FSM states, grant
// identifiers, the read strobe pattern, response kinds and winner selection.
package elbeth_mem_arbiter_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_BUSY = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   localparam logic [1:0] GNT_NONE = 2'd0;
   localparam logic [1:0] GNT_I    = 2'd1;
   localparam logic [1:0] GNT_D    = 2'd2;

   localparam logic [3:0] RW_READ = 4'b0000;

   localparam logic RESP_OK  = 1'b0;
   localparam logic RESP_ERR = 1'b1;

   // Fixed mode: D beats I. Round-robin: on a tie the requester that was
   // not granted last wins; a lone requester always wins.
   function automatic logic [1:0] pick_winner(input logic       rr_mode,
                                              input logic       i_en,
                                              input logic       d_en,
                                              input logic [1:0] last_grant);
      logic [1:0] w;
      w = GNT_NONE;
      if (i_en && d_en) begin
         if (rr_mode)
            w = (last_grant == GNT_D) ? GNT_I : GNT_D;
         else
            w = GNT_D;
      end else if (d_en) begin
         w = GNT_D;
      end else if (i_en) begin
         w = GNT_I;
      end
      return w;
   endfunction

endpackage

// File: rtl/elbeth_timeout_counter.sv
// Saturating 8-bit cycle counter that flags when a memory access has been
// outstanding for TIMEOUT cycles without a response.
module elbeth_timeout_counter #(
   parameter int TIMEOUT = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam logic [7:0] LIMIT = 8'(TIMEOUT);

   logic [7:0] count;

   // Count busy cycles; saturate at the limit so the value never wraps.
   always_ff @(posedge clk) begin
      if (rst || clear)
         count <= 8'd0;
      else if (enable && (count != LIMIT))
         count <= count + 8'd1;
   end

   // Expiry is flagged during the TIMEOUT-th busy cycle so the access ends
   // after exactly TIMEOUT cycles with mem_en high.
   assign expired = enable && (count >= (LIMIT - 8'd1));

endmodule

// File: rtl/elbeth_mem_arbiter.sv
// Arbitrates the core's instruction and data ports onto one memory port.
// A three-state FSM (IDLE/BUSY/RESP) serialises accesses and steers the
// read data and completion/error pulse back to the granted requester.
module elbeth_mem_arbiter
   import elbeth_mem_arbiter_pkg::*;
#(
   parameter int ADDR_W  = 12,
   parameter int DATA_W  = 32,
   parameter int RR_MODE = 0,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_en,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic [3:0]        i_rw,
   input  logic [DATA_W-1:0] i_wdata,
   output logic [DATA_W-1:0] i_rdata,
   output logic              i_ready,
   output logic              i_error,
   input  logic              d_en,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [3:0]        d_rw,
   input  logic [DATA_W-1:0] d_wdata,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_ready,
   output logic              d_error,
   output logic              mem_en,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [3:0]        mem_rw,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ready,
   input  logic              mem_error
);

   logic [1:0] state;
   logic [1:0] grant;
   logic [1:0] last_grant;
   logic       kind;
   logic [1:0] winner;
   logic       expired;

   assign winner = pick_winner(RR_MODE != 0, i_en, d_en, last_grant);

   elbeth_timeout_counter #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout (
      .clk     (clk),
      .rst     (rst),
      .clear   (state != ST_BUSY),
      .enable  (state == ST_BUSY),
      .expired (expired)
   );

   // Arbitration FSM together with the registered memory-side request and
   // the per-requester read data registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         grant      <= GNT_NONE;
         last_grant <= GNT_I;
         kind       <= RESP_OK;
         mem_en     <= 1'b0;
         mem_addr   <= '0;
         mem_rw     <= RW_READ;
         mem_wdata  <= '0;
         i_rdata    <= '0;
         d_rdata    <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (winner != GNT_NONE) begin
                  state      <= ST_BUSY;
                  grant      <= winner;
                  last_grant <= winner;
                  mem_en     <= 1'b1;
                  if (winner == GNT_D) begin
                     mem_addr  <= d_addr;
                     mem_rw    <= d_rw;
                     mem_wdata <= d_wdata;
                  end else begin
                     mem_addr  <= i_addr;
                     mem_rw    <= i_rw;
                     mem_wdata <= i_wdata;
                  end
               end
            end
            ST_BUSY: begin
               // Error wins over a simultaneous ready; rdata is kept on error.
               if (mem_error || (!mem_ready && expired)) begin
                  kind   <= RESP_ERR;
                  mem_en <= 1'b0;
                  state  <= ST_RESP;
               end else if (mem_ready) begin
                  if (grant == GNT_D)
                     d_rdata <= mem_rdata;
                  else
                     i_rdata <= mem_rdata;
                  kind   <= RESP_OK;
                  mem_en <= 1'b0;
                  state  <= ST_RESP;
               end
            end
            ST_RESP: begin
               state <= ST_IDLE;
               grant <= GNT_NONE;
            end
            default: begin
               state <= ST_IDLE;
               grant <= GNT_NONE;
            end
         endcase
      end
   end

   // Completion pulses are decoded from the RESP state and the latched grant.
   assign i_ready = (state == ST_RESP) && (grant == GNT_I) && (kind == RESP_OK);
   assign i_error = (state == ST_RESP) && (grant == GNT_I) && (kind == RESP_ERR);
   assign d_ready = (state == ST_RESP) && (grant == GNT_D) && (kind == RESP_OK);
   assign d_error = (state == ST_RESP) && (grant == GNT_D) && (kind == RESP_ERR);

endmodule

// File: doc/elbeth_mem_arbiter.md
Name: elbeth_mem_arbiter

Overview:
- Shares one physical memory port between the core's instruction-fetch port (I) and data-access port (D).
- Sits between the core's processor-side memory bridge and a single-ported 4 KiB memory.
- Serialises requests with a registered FSM, forwards write strobes and data, and routes read data, ready and error back to the granted requester.
- Guarantees forward progress with selectable fixed or round-robin priority and a response timeout.

Parameters:
- ADDR_W, 12, address width of all ports.
- DATA_W, 32, data width of all ports.
- RR_MODE, 0, 0 = fixed priority with D over I; 1 = round-robin where the last-granted requester has the lowest priority.
- TIMEOUT, 255, cycles in BUSY without mem_ready/mem_error before an error is generated; range 1..255.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- i_en  in  1  instruction requester request; held until i_ready or i_error.
- i_addr  in  ADDR_W  instruction address.
- i_rw  in  4  byte write strobes; 4'b0000 = read.
- i_wdata  in  DATA_W  instruction-side write data.
- i_rdata  out  DATA_W  read data returned to I.
- i_ready  out  1  one-cycle completion pulse to I.
- i_error  out  1  one-cycle error pulse to I.
- d_en, d_addr, d_rw, d_wdata, d_rdata, d_ready, d_error  same directions, widths and meanings as the I port, for the data requester.
- mem_en  out  1  request to memory.
- mem_addr  out  ADDR_W  memory address.
- mem_rw  out  4  memory write strobes.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data.
- mem_ready  in  1  memory completion; valid only while mem_en=1.
- mem_error  in  1  memory error; valid only while mem_en=1.

Behaviour:
- Reset, applied on the clock edge with rst=1:
  - state=IDLE, grant=NONE, last_grant=I, timeout counter=0.
  - All outputs 0, including mem_en, mem_addr, mem_rw, mem_wdata, i_/d_rdata, ready and error.
- Reset mid-transaction: the in-flight access is abandoned and no ready/error pulse is issued. mem_en is low from the cycle after the reset edge.
- States: IDLE, BUSY, RESP.
- IDLE:
  - With no requester enabled, outputs hold their idle values.
  - If i_en or d_en is high, select a winner:
    - RR_MODE=0: D wins if d_en, else I.
    - RR_MODE=1: if both are high, the requester not equal to last_grant wins; otherwise the single requester wins.
  - At the edge: latch winner addr/rw/wdata into mem_* registers, set mem_en=1, grant=winner, last_grant=winner, counter=0, and go to BUSY.
- BUSY:
  - mem_* outputs are stable, driven from registers.
  - Requester inputs are ignored; changes to them during BUSY have no effect.
  - The counter increments each cycle.
  - On mem_ready=1: latch mem_rdata into the granted requester's rdata register, set response kind=OK, mem_en=0, and go to RESP.
  - On mem_error=1: set kind=ERR, mem_en=0, and go to RESP. The granted rdata is unchanged.
  - If mem_ready and mem_error are both high, error takes precedence.
  - If the counter reaches TIMEOUT with neither asserted: kind=ERR, mem_en=0, go to RESP.
- RESP (exactly one cycle):
  - The granted requester's ready (kind OK) or error (kind ERR) is high.
  - The other requester's ready and error stay 0.
  - Next state is always IDLE; grant=NONE.
- Latency:
  - Request to mem_en: 1 cycle (en sampled in IDLE, mem_en high the next cycle).
  - mem_ready to requester ready: 1 cycle.
  - Minimum transaction: 3 cycles; back-to-back throughput is one access per 3 cycles.
- Requester contract:
  - en must be low in the IDLE cycle following its ready/error pulse, unless it issues a new request.
  - A request held high is re-arbitrated like a new one.
- rdata registers hold their last value until the next successful read for that requester.
- Writes also update rdata with mem_rdata on mem_ready; requesters ignore it.
- Timeout counter is 8 bits. It is cleared on entry to BUSY and never wraps, because it saturates at TIMEOUT.

Decomposition:
- Shared constants header elbeth_mem_defs.vh contains:
  - State encoding: IDLE=2'd0, BUSY=2'd1, RESP=2'd2.
  - Grant IDs: NONE=2'd0, I=2'd1, D=2'd2.
  - RW_READ=4'b0000.
  - Response kinds: OK=1'b0, ERR=1'b1.
- One sub-module, elbeth_timeout_counter (clk, rst, clear, enable, expired), parameterised by TIMEOUT.

Test Plan:
- Single read: d_en=1, d_addr=12'h010, d_rw=0; memory returns 32'hDEADBEEF with mem_ready 2 cycles after mem_en. Required: mem_addr=12'h010; d_rdata=32'hDEADBEEF; d_ready is a single pulse 1 cycle later; i_ready stays 0.
- Simultaneous requests, RR_MODE=0: i_en=d_en=1 in the same IDLE cycle. Required: D granted first and I second; mem_addr sequence is d_addr then i_addr.
- Round-robin, RR_MODE=1: both requesters held high for 4 transactions. Required: grants alternate D, I, D, I, since last_grant resets to I.
- Write with strobes: i_rw=4'b0011, i_wdata=32'h12345678. Required: mem_rw=4'b0011 and mem_wdata=32'h12345678 stable for all BUSY cycles; i_ready pulses once.
- Timeout and error: TIMEOUT=4, memory never responds. Required: mem_en high for exactly 4 cycles, then the requester's error pulses for 1 cycle. Separately, mem_ready=mem_error=1 in the same cycle yields error and no ready.
- Reset in BUSY: assert rst for 1 cycle mid-transaction. Required: next cycle mem_en=0, no ready/error pulse, state IDLE; a new d_en is served normally.
